// File: rtl/instr_fetch.sv
// MIPS fetch stage: owns the PC, drives the word address to a combinational
// instruction memory and registers the returned word into the IF/ID register.
module instr_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_WORD   = 32,
  parameter int                    MEM_DEPTH  = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  br_taken,
  input  logic [ADDR_WIDTH-1:0] br_target,
  input  logic                  jmp,
  input  logic [ADDR_WIDTH-1:0] jmp_target,
  input  logic                  halt_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [MEM_WORD-1:0]   imem_data,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [MEM_WORD-1:0]   if_id_instr,
  output logic [ADDR_WIDTH-1:0] if_id_pc4,
  output logic                  if_id_valid,
  output logic                  if_id_oob,
  output logic                  misalign
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] FOUR    = ADDR_WIDTH'(4);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [MEM_WORD-1:0]   instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] pc4_q, pc4_d;
  logic                  valid_q, valid_d;
  logic                  oob_q, oob_d;
  logic                  misalign_q, misalign_d;

  logic                  active;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] sel_target;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;

  assign word_idx   = {2'b00, pc_q[ADDR_WIDTH-1:2]};
  assign imem_addr  = word_idx;
  assign pc_plus4   = pc_q + FOUR;
  assign in_range   = (word_idx < DEPTH_W);
  assign active     = (state_q == S_RUN) || (state_q == S_HALT);
  // Redirects are ignored in BOOT; branch beats jump because it is the older instruction.
  assign redirect   = active && (br_taken || jmp);
  assign sel_target = br_taken ? br_target : jmp_target;

  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (redirect) begin
      pc_d       = {sel_target[ADDR_WIDTH-1:2], 2'b00};
      misalign_d = |sel_target[1:0];
    end else if ((state_q == S_RUN) && !stall) begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = halt_req ? S_HALT : S_RUN;
      S_RUN:   if (halt_req && !stall && !redirect) state_d = S_HALT;
      S_HALT:  state_d = halt_req ? S_HALT : S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    oob_d   = oob_q;
    if (redirect || flush || (!stall && (state_q != S_RUN))) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
      oob_d   = 1'b0;
    end else if (!stall) begin
      // Out-of-range fetches still carry pc4 so software can locate the fault.
      instr_d = in_range ? imem_data : '0;
      pc4_d   = pc_plus4;
      valid_d = in_range;
      oob_d   = !in_range;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      oob_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      oob_q      <= oob_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign if_id_oob   = oob_q;
  assign misalign    = misalign_q;

endmodule
